// File: rtl/nv_ram_rwsp_32x256_fifo_ctl_pkg.sv
// Shared sizing for the 32-deep, 256-bit RAM-backed FIFO controller.
package nv_ram_rwsp_32x256_fifo_ctl_pkg;

  localparam int unsigned FIFO_DEPTH = 32;
  localparam int unsigned FIFO_AW    = 5;
  localparam int unsigned FIFO_DW    = 256;

  // Occupancy reaches DEPTH+1 (RAM entries plus the RAM output register).
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 2);

endpackage

// File: rtl/nv_ram_rwsp_32x256_fifo_ctl_rdpipe.sv
// Two-stage RAM read scheduler: tracks the live read address (stage 1)
// and the live output register (stage 2), and issues ram_re / ram_ore.
module nv_ram_rwsp_32x256_fifo_ctl_rdpipe
  import nv_ram_rwsp_32x256_fifo_ctl_pkg::*;
#(
  parameter int unsigned AW = FIFO_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [AW:0] occ,
  input  logic        out_ready,
  output logic        ram_re,
  output logic        ram_ore,
  output logic        s2_valid
);

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic has_unread;

  // Stage advance: ore when stage 2 frees up, re when stage 1 frees up.
  always_comb begin
    has_unread = (occ - (AW+1)'(s1_valid_q)) != '0;
    ram_ore    = s1_valid_q && (!s2_valid_q || out_ready);
    ram_re     = has_unread && (!s1_valid_q || ram_ore);
    s1_valid_d = ram_re || (s1_valid_q && !ram_ore);
    s2_valid_d = ram_ore || (s2_valid_q && !out_ready);
    s2_valid   = s2_valid_q;
  end

  // Pipeline valid flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

endmodule

// File: rtl/nv_ram_rwsp_32x256_fifo_ctl.sv
// Valid/ready FIFO controller in front of the 32x256 two-port RAM:
// streams producer beats into RAM writes and drains through the RAM's
// re/ore read pipeline toward a stallable consumer.
module nv_ram_rwsp_32x256_fifo_ctl
  import nv_ram_rwsp_32x256_fifo_ctl_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned AW    = FIFO_AW,
  parameter int unsigned DW    = FIFO_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [DW-1:0]    ram_di,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_ore,
  input  logic [DW-1:0]    ram_dout,
  output logic [CNT_W-1:0] count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          s2_valid;

  nv_ram_rwsp_32x256_fifo_ctl_rdpipe #(
    .AW (AW)
  ) u_rdpipe (
    .clk       (clk),
    .rst       (rst),
    .occ       (occ_q),
    .out_ready (out_ready),
    .ram_re    (ram_re),
    .ram_ore   (ram_ore),
    .s2_valid  (s2_valid)
  );

  // Write acceptance, RAM port drive and next-state pointer/occupancy.
  // in_ready looks only at registered occupancy, so a same-cycle ore
  // never lends a credit to the write side.
  always_comb begin
    in_ready  = !rst && (occ_q != (AW+1)'(DEPTH));
    ram_we    = in_valid && in_ready;
    ram_wa    = wr_ptr_q;
    ram_di    = in_data;
    ram_ra    = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q + AW'(ram_we);
    rd_ptr_d  = rd_ptr_q + AW'(ram_re);
    occ_d     = occ_q + (AW+1)'(ram_we) - (AW+1)'(ram_ore);
    out_valid = s2_valid;
    out_data  = ram_dout;
    count     = CNT_W'(occ_q) + CNT_W'(s2_valid);
  end

  // Pointer and occupancy flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: tb/tb_nv_ram_rwsp_32x256_fifo_ctl.sv
// Bench for the 32x256 FIFO controller: behavioural RAM beside the DUT,
// scoreboard of accepted beats, event-count reference model of occupancy.
module tb_nv_ram_rwsp_32x256_fifo_ctl;
  import nv_ram_rwsp_32x256_fifo_ctl_pkg::*;

  localparam int unsigned DW = FIFO_DW;
  localparam int unsigned AW = FIFO_AW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_ready, out_valid, ram_we, ram_re, ram_ore;
  logic [DW-1:0]    out_data, ram_di, ram_dout;
  logic [AW-1:0]    ram_wa, ram_ra;
  logic [CNT_W-1:0] count;

  nv_ram_rwsp_32x256_fifo_ctl #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW),
    .DW    (FIFO_DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_we    (ram_we),
    .ram_wa    (ram_wa),
    .ram_di    (ram_di),
    .ram_re    (ram_re),
    .ram_ra    (ram_ra),
    .ram_ore   (ram_ore),
    .ram_dout  (ram_dout),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Behavioural two-port RAM with latched read address and output register.
  logic [DW-1:0] mem [32];
  logic [AW-1:0] ra_d;
  logic [DW-1:0] dout_r;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_d <= ram_ra;
    if (ram_ore) dout_r <= mem[ra_d];
  end
  assign ram_dout = dout_r;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic [DW-1:0] sb [$];
  int unsigned wr_n = 0, rd_n = 0, ore_n = 0, pop_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: reference model from event counts (writes, reads, ores, pops).
  always @(negedge clk) begin
    logic exp_re, exp_ore, s1_live, s2_live;
    if (rst) begin
      sb.delete();
      wr_n = 0; rd_n = 0; ore_n = 0; pop_n = 0;
    end else begin
      s1_live = (rd_n != ore_n);
      s2_live = (ore_n != pop_n);
      exp_ore = s1_live && (!s2_live || out_ready);
      exp_re  = (wr_n > rd_n) && (!s1_live || exp_ore);
      chk("count", 32'(count), 32'(sb.size()));
      chk("in_ready", 32'(in_ready), 32'((wr_n - ore_n) != 32));
      chk("ram_we", 32'(ram_we), 32'(in_valid && in_ready));
      chk("out_valid", 32'(out_valid), 32'(s2_live));
      chk("ram_ore", 32'(ram_ore), 32'(exp_ore));
      chk("ram_re", 32'(ram_re), 32'(exp_re));
      if (ram_re)  chk("ram_ra", 32'(ram_ra), rd_n % 32);
      if (ram_we)  chk("ram_wa", 32'(ram_wa), wr_n % 32);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out_extra: got %h expected no output", out_data);
        end else chkd("out_data", out_data, sb.pop_front());
        pop_n++;
      end
      if (ram_we) begin sb.push_back(in_data); wr_n++; end
      if (ram_re)  rd_n++;
      if (ram_ore) ore_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned k = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (k < budget && (sb.size() != 0 || out_valid)) begin
      tick();
      k++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Single beat of fixed data; records the we/re/ore/out_valid timeline.
  task automatic single_beat(input logic [DW-1:0] d, input string tag);
    logic [4:0] we_v, re_v, ore_v, ov_v;
    logic [DW-1:0] od;
    od = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      in_valid  = (c == 0);
      in_data   = d;
      out_ready = 1'b1;
      @(negedge clk);
      we_v[c] = ram_we; re_v[c] = ram_re; ore_v[c] = ram_ore; ov_v[c] = out_valid;
      if (c == 3) od = out_data;
    end
    chk({tag, "_we_t"},  32'(we_v),  32'b00001);
    chk({tag, "_re_t"},  32'(re_v),  32'b00010);
    chk({tag, "_ore_t"}, 32'(ore_v), 32'b00100);
    chk({tag, "_ov_t"},  32'(ov_v),  32'b01000);
    chkd({tag, "_data"}, od, d);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    int unsigned a, ov_cnt, cyc;
    logic [DW-1:0] pat_a5, pat_3c;
    pat_a5 = {8{32'hA5A5A5A5}};
    pat_3c = DW'(8'h3C);

    // Reset values with a producer already asserting valid.
    in_valid = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_re", 32'(ram_re), 0);
    chk("rst_ore", 32'(ram_ore), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wa", 32'(ram_wa), 0);
    chk("rst_ra", 32'(ram_ra), 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    single_beat(pat_a5, "single");

    // Fill with consumer stalled: exactly 33 beats fit.
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 0;
    for (int c = 0; c < 40; c++) begin
      in_data = DW'(a);
      @(negedge clk);
      if (in_valid && in_ready) a++;
      tick();
    end
    chk("fill_acc", a, 33);
    chk("fill_count", 32'(count), 33);
    chk("fill_in_ready", 32'(in_ready), 0);
    // Full with same-cycle ore: no write now, ready next cycle.
    out_ready = 1'b1;
    in_data   = DW'(33);
    @(negedge clk);
    chk("fullpop_ore", 32'(ram_ore), 1);
    chk("fullpop_ready", 32'(in_ready), 0);
    chk("fullpop_we", 32'(ram_we), 0);
    tick();
    @(negedge clk);
    chk("afterpop_ready", 32'(in_ready), 1);
    tick();
    drain(200);

    // Streaming: one beat per cycle both directions.
    out_ready = 1'b1;
    a = 0; ov_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      in_valid = 1'b1;
      in_data  = rnd();
      @(negedge clk);
      if (ram_we) a++;
      if (c >= 3 && out_valid) ov_cnt++;
      tick();
    end
    chk("stream_acc", a, 100);
    chk("stream_ov", ov_cnt, 97);
    drain(200);

    // Random backpressure with continuous input.
    a = 0; cyc = 0;
    in_valid = 1'b1;
    in_data  = rnd();
    while (a < 200 && cyc < 3000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) begin
        a++;
        tick();
        in_data = rnd();
      end else tick();
      cyc++;
    end
    chk("bp_acc", a, 200);
    drain(300);

    // Reset mid-stream with ten beats held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 0; cyc = 0;
    while (a < 10 && cyc < 50) begin
      in_data = rnd();
      @(negedge clk);
      if (in_valid && in_ready) a++;
      tick();
      cyc++;
    end
    chk("prerst_count", 32'(count), 10);
    chk("prerst_ov", 32'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ov", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready), 0);
    chk("midrst_we", 32'(ram_we), 0);
    chk("midrst_re", 32'(ram_re), 0);
    chk("midrst_ore", 32'(ram_ore), 0);
    chk("midrst_count", 32'(count), 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    single_beat(pat_3c, "postrst");

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nv_ram_rwsp_32x256_fifo_ctl.md
Name: nv_ram_rwsp_32x256_fifo_ctl

Overview:
Valid/ready FIFO controller that sits directly upstream of the 32x256 two-port RAM (write port, read port with re/ore two-stage read). It turns a 256-bit streaming producer interface into RAM writes, and schedules the RAM's two-cycle read pipeline toward a stallable consumer without bubbles. Used wherever a 32-deep 256-bit elastic buffer is needed. The RAM is instantiated beside it by the parent.

Parameters:
DEPTH, 32, number of RAM entries; must equal 2**AW.
AW, 5, RAM address width.
DW, 256, data width.

Ports:
clk  input  1  core clock; also drives the RAM.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  producer has data.
in_ready  output  1  controller accepts this cycle.
in_data  input  DW  write data.
out_valid  output  1  output data valid.
out_ready  input  1  consumer accepts.
out_data  output  DW  connected from RAM dout.
ram_we  output  1  RAM write enable.
ram_wa  output  AW  RAM write address.
ram_di  output  DW  RAM write data (= in_data).
ram_re  output  1  RAM read-address latch enable.
ram_ra  output  AW  RAM read address.
ram_ore  output  1  RAM output-register enable.
ram_dout  input  DW  RAM dout.
count  output  6  entries held (RAM + output register), 0..33.

Behaviour:
- State: wr_ptr[AW-1:0], rd_ptr[AW-1:0], occ[AW:0] (written, not yet ore'd), s1_valid (RAM ra_d holds a live address), s2_valid (RAM dout_r holds live data). All flops are async-cleared by rst to 0.
- Outputs during and after reset until the first clock: in_ready=0, out_valid=0, ram_we=0, ram_re=0, ram_ore=0, count=0, ram_wa=0, ram_ra=0. RAM contents are not cleared.
- Write side:
  - in_ready = !rst && (occ != DEPTH). It depends only on registered state, with no same-cycle credit from a read.
  - ram_we = in_valid && in_ready; ram_wa = wr_ptr. wr_ptr increments mod DEPTH on each write.
- Read stage 1 (ram_re):
  - Fires when unread entries exist (occ minus s1_valid > 0) and stage 1 is free or advancing: (!s1_valid || ram_ore).
  - ram_ra = rd_ptr; rd_ptr increments mod DEPTH on each ram_re.
  - A read is never issued in the same cycle as the write it would return. Reads use registered occ only, so the write commits at the same edge and the RAM returns the new data the next cycle.
- Read stage 2 (ram_ore): ram_ore = s1_valid && (!s2_valid || out_ready).
- Pipeline state:
  - s1_valid next = ram_re || (s1_valid && !ram_ore).
  - s2_valid next = ram_ore || (s2_valid && !out_ready).
- Stall rules: while stage 1 is stalled, ram_re stays 0, so ra_d holds and the RAM entry is not freed. An entry is freed only on ram_ore.
- occ next = occ + ram_we - ram_ore. The write and the ore can happen in the same cycle.
- out_valid = s2_valid; out_data = ram_dout.
- count = occ + s2_valid. Maximum capacity is 33.
- Latency: a write accepted in cycle 0 gives ram_re in cycle 1, ram_ore in cycle 2, and out_valid in cycle 3, provided the pipeline was empty and out_ready=1.
- Throughput: one beat per cycle sustained in both directions.
- Boundaries:
  - Full (occ=32): in_ready=0, even if ram_ore fires that cycle.
  - Empty: ram_re=0.
  - Pointers wrap 31 to 0 with no special handling.
  - Simultaneous write and read of the same address cannot occur, because the occ gating prevents it.
  - Reset mid-stream: all in-flight data is discarded and outputs drop asynchronously.

Decomposition:
- Shared package: DEPTH/AW/DW constants for the 32x256 buffer, and the count-width constant (clog2(DEPTH+2)).
- One natural sub-module: nv_ram_rwsp_32x256_fifo_ctl_rdpipe. It holds s1/s2 valid tracking and generates ram_re/ram_ore.
- The RAM is instantiated by the parent, not inside this block.

Test Plan:
- Single beat: reset, then in_valid=1 with data 0xA5..A5 for one cycle, out_ready=1 -> ram_we in cycle 0 (wa=0), ram_re cycle 1 (ra=0), ram_ore cycle 2, out_valid cycle 3 with 0xA5..A5, count returns to 0.
- Fill: out_ready=0, push 40 beats of incrementing data -> 33 accepted, in_ready=0 from the cycle after count reaches 33, occ=32. Then out_ready=1 -> values 0..32 emerge in order.
- Streaming: in_valid=out_ready=1 for 100 beats -> one output per cycle after the 3-cycle fill, data in order, pointers wrap past 31 with no bubble or corruption.
- Backpressure: random out_ready (50%) with continuous input of 200 beats -> no loss or duplication. ram_ra holds while stage 1 is stalled; ram_ore never fires when s2_valid=1 and out_ready=0.
- Full plus same-cycle pop: occ=32 with ram_ore=1 and in_valid=1 -> no write that cycle; in_ready=1 the next cycle.
- Reset mid-operation: assert rst with count=10 -> out_valid, in_ready, ram_we, ram_re and ram_ore go to 0 immediately and count=0. After release, a new beat 0x3C emerges first, at cycle 3.
